pipe_stage_reg: RTL and testbench

- Generic, parametrised pipeline-stage register for the pipelined core; successor to the fixed-field ID/EX-style stage registers.
- Carries an opaque control bundle, data bundle and destination-register field between any two stages.
- Uses a valid/ready handshake and a 2-entry skid buffer, so backpressure does not form a combinational ready path.
- Flush kills in-flight entries. Bubbles always present zeroed control and rd, so a bubble is architecturally a NOP and is never a forwarding source.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_stage_slot.sv | 49 ++++
 rtl/pipe_stage_reg.sv | 194 +++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared types for the generic pipeline-stage register.
//   - state_t : fill level of a stage (EMPTY / ONE / TWO entries)
//   - occ_t   : occupancy count type (0..2)
//   - DEF_*   : default payload widths
package pipe_pkg;

  localparam int DEF_CTRL_W = 16;
  localparam int DEF_DATA_W = 128;
  localparam int DEF_RD_W   = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef logic [1:0] occ_t;

endpackage

// File: rtl/pipe_stage_slot.sv
// pipe_stage_slot
//   One storage slot {valid, ctrl, data, rd} of a pipeline-stage register.
//   State updates on the falling clock edge; asynchronous active-low reset.
//   Ports:
//     clk, rst           falling-edge clock, async active-low reset
//     load               capture d_ctrl/d_data/d_rd and set valid
//     clear              drop the entry: valid, ctrl and rd go to zero,
//                        data keeps its last value (clear wins over load)
//     d_ctrl/d_data/d_rd next entry contents
//     valid/ctrl/data/rd held entry
module pipe_stage_slot #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  input  logic [RD_W-1:0]   d_rd,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data,
  output logic [RD_W-1:0]   rd
);

  // Clearing zeroes ctrl/rd so an empty slot reads as a NOP and can never
  // act as a forwarding source; data is left alone since it is don't-care.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
      rd    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      rd    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
      data  <= d_data;
      rd    <= d_rd;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Generic pipeline-stage register with a valid/ready handshake and a
//   2-entry skid buffer (main slot drives the outputs, skid slot absorbs one
//   entry of backpressure). in_ready comes straight from the state register,
//   so there is no combinational path from out_ready to in_ready.
//   All state changes on the falling edge of clk; rst is async active-low.
//   Optional feature macro: PIPE_STAGE_PERF_EN adds stall_cnt/bubble_cnt.
//   Ports:
//     clk, rst                    clock (falling edge), async active-low reset
//     flush                       synchronous kill of held and incoming entries
//     in_valid/in_ready           upstream handshake (in_ready registered)
//     in_ctrl/in_data/in_rd       upstream entry
//     out_valid/out_ready         downstream handshake
//     out_ctrl/out_data/out_rd    output entry (ctrl/rd zero when invalid)
//     occupancy                   entries held, 0..2
//     stall_cnt, bubble_cnt       saturating perf counters (macro only)
module pipe_stage_reg import pipe_pkg::*; #(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_W   = DEF_RD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  state_t state, state_next;

  logic accept, drain;
  logic main_load, main_clear, main_from_skid;
  logic skid_load, skid_clear;
  logic main_valid, skid_valid;

  logic [CTRL_W-1:0] main_d_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_d_data, skid_data;
  logic [RD_W-1:0]   main_d_rd, skid_rd;

  assign in_ready  = (state != TWO);
  assign out_valid = main_valid;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    occ_t occ;
    occ       = {1'b0, main_valid} + {1'b0, skid_valid};
    occupancy = occ;
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_next;
  end

  // Flush overrides everything: both slots are cleared and any incoming
  // entry is ignored. A drain in the flush cycle needs no action here since
  // the main slot is being emptied anyway.
  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_next = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            main_load  = 1'b1;
          end
        end
        ONE: begin
          if (drain && accept) begin
            main_load = 1'b1;
          end else if (drain) begin
            state_next = EMPTY;
            main_clear = 1'b1;
          end else if (accept) begin
            state_next = TWO;
            skid_load  = 1'b1;
          end
        end
        TWO: begin
          // Skid entry moves up; in_ready is low so nothing new arrives.
          if (drain) begin
            state_next     = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          state_next = EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    main_d_ctrl = in_ctrl;
    main_d_data = in_data;
    main_d_rd   = in_rd;
    if (main_from_skid) begin
      main_d_ctrl = skid_ctrl;
      main_d_data = skid_data;
      main_d_rd   = skid_rd;
    end
  end

  pipe_stage_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W),
    .RD_W   (RD_W)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .load   (main_load),
    .clear  (main_clear),
    .d_ctrl (main_d_ctrl),
    .d_data (main_d_data),
    .d_rd   (main_d_rd),
    .valid  (main_valid),
    .ctrl   (out_ctrl),
    .data   (out_data),
    .rd     (out_rd)
  );

  pipe_stage_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W),
    .RD_W   (RD_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .clear  (skid_clear),
    .d_ctrl (in_ctrl),
    .d_data (in_data),
    .d_rd   (in_rd),
    .valid  (skid_valid),
    .ctrl   (skid_ctrl),
    .data   (skid_data),
    .rd     (skid_rd)
  );

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Counters saturate; a flush only resets a counter that has saturated,
  // otherwise flush cycles are counted like any other cycle.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (flush && (stall_cnt == CNT_MAX)) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= '0;
    end else if (flush && (bubble_cnt == CNT_MAX)) begin
      bubble_cnt <= '0;
    end else if (!out_valid && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
//   Directed bench for pipe_stage_reg with a scoreboard queue. Inputs are
//   driven 1 time unit after the rising edge; the DUT updates on the falling
//   edge; the monitor samples 3 time units after the rising edge.
//   With PIPE_STAGE_PERF_EN defined the perf counters are also exercised.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int CW = 16;
  localparam int DW = 128;
  localparam int RW = 5;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic [RW-1:0] r;
  } ent_t;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic [RW-1:0] in_rd;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_rd;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   bubble_cnt;
`endif

  ent_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .RD_W(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] mk_ctrl(input logic [RW-1:0] r);
    return {8'hA5, 3'b000, r};
  endfunction

  function automatic logic [DW-1:0] mk_data(input logic [RW-1:0] r);
    return {4{8'h3C, 19'h0, r}};
  endfunction

  task automatic check_output(input string name, input logic [DW-1:0] act,
                              input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one entry until accepted (bounded); called at rise+1.
  task automatic apply_stimulus(input logic [RW-1:0] r);
    ent_t e;
    in_valid = 1'b1;
    in_rd    = r;
    in_ctrl  = mk_ctrl(r);
    in_data  = mk_data(r);
    for (int n = 0; n < 50; n++) begin
      if (in_ready) begin
        e.c = mk_ctrl(r);
        e.d = mk_data(r);
        e.r = r;
        sb.push_back(e);
        step();
        in_valid = 1'b0;
        return;
      end
      step();
    end
    in_valid = 1'b0;
    n_checks++;
    $display("[TB] FAIL accept_timeout rd=%0d: in_ready never rose", r);
  endtask

  // Monitor: pops the scoreboard on every transfer, checks bubbles otherwise.
  initial begin
    ent_t e;
    forever begin
      @(posedge clk);
      #3;
      if (rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL unexpected_out: got rd=%0d, expected no entry", out_rd);
        end else begin
          e = sb.pop_front();
          check_output("out_rd", DW'(out_rd), DW'(e.r));
          check_output("out_ctrl", DW'(out_ctrl), DW'(e.c));
          check_output("out_data", out_data, e.d);
        end
      end else if (!out_valid) begin
        check_output("bubble_ctrl", DW'(out_ctrl), '0);
        check_output("bubble_rd", DW'(out_rd), '0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] s0, b0;
`endif
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 16'hFFFF;
    in_data   = '1;
    in_rd     = 5'h1F;
    out_ready = 1'b0;

    // Reset held with an offered entry: nothing may be captured.
    repeat (3) step();
    check_output("rst_out_valid", DW'(out_valid), '0);
    check_output("rst_out_ctrl", DW'(out_ctrl), '0);
    check_output("rst_out_rd", DW'(out_rd), '0);
    check_output("rst_out_data", out_data, '0);
    check_output("rst_occupancy", DW'(occupancy), '0);
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    check_output("rst_in_ready", DW'(in_ready), 1);
    check_output("rst_occ_after", DW'(occupancy), '0);

    // Streaming rd=1..8 with downstream always ready.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) check_output("stream_occ", DW'(occupancy), 1);
      check_output("stream_in_ready", DW'(in_ready), 1);
      apply_stimulus(RW'(i));
    end
    check_output("stream_occ_last", DW'(occupancy), 1);
    step();
    check_output("stream_occ_drained", DW'(occupancy), 0);
    check_output("stream_sb_empty", DW'(sb.size()), 0);

    // Backpressure: two held, third refused until space opens.
    out_ready = 1'b0;
    apply_stimulus(5'd3);
    apply_stimulus(5'd4);
    in_valid = 1'b1;
    in_rd    = 5'd5;
    in_ctrl  = mk_ctrl(5'd5);
    in_data  = mk_data(5'd5);
    check_output("bp_occ_two", DW'(occupancy), 2);
    check_output("bp_in_ready", DW'(in_ready), 0);
    step();
    check_output("bp_occ_hold", DW'(occupancy), 2);
    check_output("bp_in_ready_hold", DW'(in_ready), 0);
    check_output("bp_head_rd", DW'(out_rd), 3);
    out_ready = 1'b1;
    apply_stimulus(5'd5);
    repeat (3) step();
    check_output("bp_sb_empty", DW'(sb.size()), 0);
    check_output("bp_occ_end", DW'(occupancy), 0);

    // Flush while TWO, with an offered entry that must be dropped.
    out_ready = 1'b0;
    apply_stimulus(5'd3);
    apply_stimulus(5'd4);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_rd    = 5'd7;
    in_ctrl  = mk_ctrl(5'd7);
    in_data  = mk_data(5'd7);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    check_output("flush2_out_valid", DW'(out_valid), 0);
    check_output("flush2_out_ctrl", DW'(out_ctrl), 0);
    check_output("flush2_out_rd", DW'(out_rd), 0);
    check_output("flush2_occ", DW'(occupancy), 0);
    check_output("flush2_in_ready", DW'(in_ready), 1);

    // Flush while ONE: in_ready is high but the incoming entry is dropped.
    apply_stimulus(5'd9);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_rd    = 5'd10;
    in_ctrl  = mk_ctrl(5'd10);
    in_data  = mk_data(5'd10);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    check_output("flush1_occ", DW'(occupancy), 0);
    check_output("flush1_out_valid", DW'(out_valid), 0);
    out_ready = 1'b1;
    repeat (3) step();
    check_output("flush_nothing_leaks", DW'(occupancy), 0);

    // Asynchronous reset between edges while two entries are held.
    out_ready = 1'b0;
    apply_stimulus(5'd3);
    apply_stimulus(5'd4);
    check_output("areset_occ_before", DW'(occupancy), 2);
    rst = 1'b0;
    #1;
    check_output("areset_occ", DW'(occupancy), 0);
    check_output("areset_out_valid", DW'(out_valid), 0);
    check_output("areset_out_rd", DW'(out_rd), 0);
    check_output("areset_out_ctrl", DW'(out_ctrl), 0);
    check_output("areset_out_data", out_data, 0);
    sb.delete();
    step();
    rst = 1'b1;
    step();
    check_output("areset_in_ready", DW'(in_ready), 1);

`ifdef PIPE_STAGE_PERF_EN
    // Five stalled cycles, then one drain, then three bubbles.
    out_ready = 1'b0;
    apply_stimulus(5'd1);
    s0 = stall_cnt;
    repeat (5) step();
    check_output("perf_stall", DW'(stall_cnt - s0), 5);
    out_ready = 1'b1;
    step();
    b0 = bubble_cnt;
    s0 = stall_cnt;
    repeat (3) step();
    check_output("perf_bubble", DW'(bubble_cnt - b0), 3);
    check_output("perf_stall_idle", DW'(stall_cnt - s0), 0);
`endif

    step();
    check_output("final_sb_empty", DW'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
